spi_bus_master: RTL and testbench
=================================

Name: spi_bus_master

Overview:
- SPI-master initiator for the register/RAM SPI protocol served by the FPGA-side bus slave.
- A local request interface (read/write, 7-bit address, 32-bit data) is serialised into one CS frame:
  - command byte {rw, addr[6:0]}, with rw=1 for write;
  - then four data bytes, MSB first.
- On reads, the four MISO bytes are captured and returned.
- Used by test fixtures and the board controller to reach the slave's 128×32 RAM.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1).
- GAP_CYCLES, 16, idle clk cycles with SCLK low between bytes inside a frame (≥0). Slave byte-strobe sync and its RAM read-cycle need this gap.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE; transfer on req_valid&req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  7  word address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse at frame completion (read and write)
- rsp_rdata  out  32  read data; valid with rsp_valid on reads
- spi_cs  out  1  chip select, active-low (1=idle)
- spi_sclk  out  1  SPI clock, mode 0 (idle low)
- spi_mosi  out  1  master data out
- spi_miso  in  1  slave data in

Behaviour:
- Reset values:
  - req_ready=1 after reset release;
  - rsp_valid=0, rsp_rdata=0;
  - spi_cs=1, spi_sclk=0, spi_mosi=0;
  - FSM in IDLE, all counters 0.
- Async reset mid-frame: CS deasserts immediately; the partial frame is dropped; no rsp_valid.
- On accept, latch {write, addr, wdata}. Later changes on req_* are ignored.
- FSM states: IDLE → CS_SETUP → SHIFT → (GAP → SHIFT)×4 → CS_HOLD → DONE → IDLE.
- IDLE:
  - req_ready=1, cs=1;
  - on accept, go to CS_SETUP.
- CS_SETUP:
  - cs=0 for CLK_DIV cycles;
  - mosi = bit7 of the current byte.
- SHIFT: 8 bits, MSB first. Each bit is CLK_DIV cycles sclk=0, then CLK_DIV cycles sclk=1.
  - MISO is sampled on the cycle sclk rises.
  - MOSI updates on the cycle sclk falls.
  - After bit0's high phase, sclk returns low:
    - if byte_cnt<4, go to GAP;
    - otherwise go to CS_HOLD.
- Byte contents:
  - byte0 = {write, addr};
  - bytes1–4, write: wdata[31:24], [23:16], [15:8], [7:0];
  - bytes1–4, read: 0x00 on MOSI.
- GAP: GAP_CYCLES cycles with cs=0 and sclk=0; byte_cnt increments; then SHIFT.
- CS_HOLD: CLK_DIV cycles, cs=0, sclk=0. Then DONE.
- DONE:
  - cs=1 and rsp_valid=1 for exactly 1 cycle;
  - read: rsp_rdata = {b1,b2,b3,b4} from MISO, byte0's MISO ignored;
  - write: rsp_rdata unchanged;
  - next cycle IDLE; back-to-back requests therefore see ≥1 cycle of cs=1.
- Frame length: 2·CLK_DIV + 80·CLK_DIV + 4·GAP_CYCLES + 1 cycles. Defaults give 393 cycles, cs low for 392.
- Divider counter width is clog2(CLK_DIV)+1. The gap counter is sized for GAP_CYCLES. GAP_CYCLES=0 skips the GAP state.
- req_valid during a frame: held off (req_ready=0), no loss.

Optional Feature:
- Macro SPI_BUS_MASTER_TXN_CNT_EN.
- Defined:
  - extra output txn_cnt[15:0], reset 0;
  - increments on each rsp_valid, wraps 0xFFFF→0.
- Undefined: port and logic absent; otherwise identical.

Decomposition:
- Package spi_bus_pkg:
  - CMD_WRITE_BIT=7, ADDR_W=7, DATA_W=32, DATA_BYTES=4;
  - FSM state enum shared with slave-side code.
- One sub-module, spi_byte_shifter:
  - 8-bit mode-0 shift engine with divider;
  - start/done handshake, tx_byte in, rx_byte out.
- Frame FSM, byte counter and gap timer stay in spi_bus_master.

Test Plan:
- Write addr 0x15, wdata 0xDEADBEEF, defaults → MOSI bytes 0x95,0xDE,0xAD,0xBE,0xEF; cs low for 392 cycles; one rsp_valid.
- Read addr 0x03 with slave model returning 0x12345678 → MOSI 0x03,00,00,00,00; rsp_rdata=0x12345678 on the rsp_valid cycle.
- Mode-0 timing, CLK_DIV=1, GAP_CYCLES=0 → sclk period 2 clk, MISO sampled on the rising cycle, MOSI stable across rising edges; frame 83 cycles.
- req_valid held high over two requests → second accepted only after DONE; cs high ≥1 cycle between frames; req_* changes mid-frame have no effect.
- rst asserted in byte 2 → cs=1, sclk=0 same cycle (async); no rsp_valid; next request completes normally.
- SPI_BUS_MASTER_TXN_CNT_EN defined, 3 transactions → txn_cnt=3; preload 0xFFFF via force, one more → 0x0000.

Source files
------------

// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI register/RAM bus: field widths, the frame FSM
// state encoding and the frame byte selector.
package spi_bus_pkg;

  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_W        = 7;
  localparam int DATA_W        = 32;
  localparam int DATA_BYTES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_CS_HOLD,
    ST_DONE
  } spi_state_t;

  // Byte idx of a frame: 0 is the command byte, 1..4 the data bytes MSB first.
  // Reads put zeros on MOSI during the data bytes.
  function automatic logic [7:0] frame_byte(input logic [2:0]        idx,
                                            input logic              write,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] wdata);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: begin
        b = {1'b0, addr};
        b[CMD_WRITE_BIT] = write;
      end
      3'd1: if (write) b = wdata[31:24];
      3'd2: if (write) b = wdata[23:16];
      3'd3: if (write) b = wdata[15:8];
      3'd4: if (write) b = wdata[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI engine for one byte: CLK_DIV clocks per SCLK half-period, MISO
// sampled as SCLK rises, MOSI advanced as SCLK falls, done in the last cycle.
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             busy;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic             phase_end;

  assign phase_end = busy && (div_cnt == DIV_LAST);
  assign done      = phase_end && sclk && (bit_cnt == 3'd7);
  assign mosi      = tx_sh[7];

  // A start coinciding with done reloads immediately, so bytes can run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'h00;
      rx_byte <= 8'h00;
      sclk    <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      tx_sh   <= tx_byte;
      sclk    <= 1'b0;
    end else if (busy) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk    <= 1'b1;
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          sclk    <= 1'b0;
          tx_sh   <= {tx_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) busy <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_master.sv
// SPI bus master: one CS frame per request (command byte + 4 data bytes).
// Optional SPI_BUS_MASTER_TXN_CNT_EN adds a 16-bit completed-transaction counter.
module spi_bus_master
  import spi_bus_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_cs,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
`ifdef SPI_BUS_MASTER_TXN_CNT_EN
  ,
  output logic [15:0]       txn_cnt
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  spi_state_t        state, state_nxt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        byte_cnt;
  logic [2:0]        start_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] rd_sh;
  logic              div_last, gap_last, last_byte;
  logic              sh_start, sh_done, sh_mosi;
  logic [7:0]        tx_byte, cur_byte, rx_byte;

  assign div_last  = (div_cnt == DIV_LAST);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign last_byte = (byte_cnt == 3'(DATA_BYTES));
  assign tx_byte   = frame_byte(start_idx, write_q, addr_q, wdata_q);
  assign cur_byte  = frame_byte(byte_cnt, write_q, addr_q, wdata_q);

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (sh_start),
    .tx_byte (tx_byte),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (sh_mosi),
    .done    (sh_done),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The shifter is started in the last cycle of CS_SETUP/GAP so SHIFT begins on the next edge.
  always_comb begin
    state_nxt = state;
    sh_start  = 1'b0;
    start_idx = byte_cnt;
    case (state)
      ST_IDLE:     if (req_valid) state_nxt = ST_CS_SETUP;
      ST_CS_SETUP: if (div_last) begin
        state_nxt = ST_SHIFT;
        sh_start  = 1'b1;
        start_idx = 3'd0;
      end
      ST_SHIFT: if (sh_done) begin
        if (last_byte) begin
          state_nxt = ST_CS_HOLD;
        end else if (GAP_CYCLES == 0) begin
          sh_start  = 1'b1;
          start_idx = byte_cnt + 3'd1;
        end else begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: if (gap_last) begin
        state_nxt = ST_SHIFT;
        sh_start  = 1'b1;
      end
      ST_CS_HOLD:  if (div_last) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_cnt  <= 3'd0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      rd_sh     <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == ST_IDLE) begin
        byte_cnt <= 3'd0;
        if (req_valid) begin
          write_q <= req_write;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
      end
      if ((state == ST_CS_SETUP || state == ST_CS_HOLD) && !div_last) div_cnt <= div_cnt + 1'b1;
      else                                                            div_cnt <= '0;
      if (state == ST_GAP && !gap_last) gap_cnt <= gap_cnt + 1'b1;
      else                              gap_cnt <= '0;
      // Byte 0's MISO is the slave's turnaround and is never kept.
      if (state == ST_SHIFT && sh_done) begin
        if (!last_byte) byte_cnt <= byte_cnt + 3'd1;
        if (byte_cnt != 3'd0) rd_sh <= {rd_sh[DATA_W-9:0], rx_byte};
      end
      if (state == ST_CS_HOLD && div_last && !write_q) rsp_rdata <= rd_sh;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign spi_cs    = !(state inside {ST_CS_SETUP, ST_SHIFT, ST_GAP, ST_CS_HOLD});
  assign spi_mosi  = (state == ST_SHIFT) ? sh_mosi :
                     (state inside {ST_CS_SETUP, ST_GAP}) ? cur_byte[7] : 1'b0;

`ifdef SPI_BUS_MASTER_TXN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    txn_cnt <= 16'h0000;
    else if (state == ST_DONE)  txn_cnt <= txn_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_spi_bus_master.sv
// Scoreboard bench for spi_bus_master: instance 0 uses defaults, instance 1 uses
// CLK_DIV=1/GAP_CYCLES=0. A bench slave model drives MISO; monitors check frames and responses.
module tb_spi_bus_master;

  typedef struct {
    int          inst;
    logic [39:0] mosi;
    logic [31:0] slave_word;
    int          low_cycles;
  } frame_t;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [6:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        cs        [2];
  logic        sclk      [2];
  logic        mosi      [2];
  logic        miso      [2];
`ifdef SPI_BUS_MASTER_TXN_CNT_EN
  logic [15:0] txn_cnt   [2];
`endif

  frame_t frame_q[$];
  rsp_t   rsp_q[$];
  int     checks = 0;
  int     errors = 0;

  logic        prev_cs   [2] = '{1'b1, 1'b1};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  logic        abort     [2] = '{1'b0, 1'b0};
  int          low_cnt   [2] = '{0, 0};
  int          bit_cnt   [2] = '{0, 0};
  int          rise_gap  [2] = '{0, 0};
  logic [39:0] cap       [2];
  logic [39:0] slv       [2];
  int          half_per  [2] = '{4, 1};
  int          cs_low    [2] = '{392, 82};

  always #5 clk = ~clk;

  spi_bus_master dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .spi_cs(cs[0]),
    .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
`ifdef SPI_BUS_MASTER_TXN_CNT_EN
    , .txn_cnt(txn_cnt[0])
`endif
  );

  spi_bus_master #(.CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .spi_cs(cs[1]),
    .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
`ifdef SPI_BUS_MASTER_TXN_CNT_EN
    , .txn_cnt(txn_cnt[1])
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one request; expectations are pushed before the request is driven.
  task automatic applyStimulus(input int i, input logic w, input logic [6:0] a,
                               input logic [31:0] d, input logic [31:0] sw,
                               input logic [39:0] exp_mosi, input logic [31:0] exp_rdata,
                               input bit hold, output int waited);
    frame_q.push_back('{i, exp_mosi, sw, cs_low[i]});
    rsp_q.push_back('{i, exp_rdata});
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    waited = 0;
    while (!req_ready[i] && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!req_ready[i]) begin
      errors++;
      $display("[TB] FAIL accept_timeout: inst %0d req_ready stayed 0, expected 1", i);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      req_valid[i] = 1'b0;
      req_write[i] = ~w;
      req_addr[i]  = ~a;
      req_wdata[i] = ~d;
    end
  endtask

  task automatic waitDone();
    int n = 0;
    while ((frame_q.size() != 0 || rsp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d frames and %0d responses pending, expected 0",
               frame_q.size(), rsp_q.size());
    end
  endtask

  // Slave model plus frame and response monitors, all sampled on the falling clk edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rise_gap[i]++;
      if (!cs[i] && prev_cs[i]) begin
        low_cnt[i] = 0;
        bit_cnt[i] = 0;
        cap[i]     = '0;
        rise_gap[i] = 0;
        if (frame_q.size() == 0) begin
          checkOutput("unexpected_frame", 64'(i), 64'hFF);
          slv[i] = '0;
        end else begin
          slv[i] = {8'h00, frame_q[0].slave_word};
        end
        miso[i] = slv[i][39];
      end
      if (!cs[i]) begin
        low_cnt[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          checkOutput("mosi_stable", 64'(mosi[i]), 64'(prev_mosi[i]));
          if (bit_cnt[i] % 8 != 0)
            checkOutput("sclk_period", 64'(rise_gap[i]), 64'(2 * half_per[i]));
          rise_gap[i] = 0;
          cap[i] = {cap[i][38:0], mosi[i]};
          bit_cnt[i]++;
        end
        if (!sclk[i] && prev_sclk[i]) begin
          slv[i] = {slv[i][38:0], 1'b0};
          miso[i] = slv[i][39];
        end
      end
      if (cs[i] && !prev_cs[i]) begin
        if (abort[i]) begin
          abort[i] = 1'b0;
          if (frame_q.size() != 0) void'(frame_q.pop_front());
        end else if (frame_q.size() != 0) begin
          frame_t f;
          f = frame_q.pop_front();
          checkOutput("frame_inst", 64'(i), 64'(f.inst));
          checkOutput("mosi_bytes", 64'(cap[i]), 64'(f.mosi));
          checkOutput("sclk_rises", 64'(bit_cnt[i]), 64'd40);
          checkOutput("cs_low_cycles", 64'(low_cnt[i]), 64'(f.low_cycles));
        end
      end
      if (rsp_valid[i]) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(i), 64'hFF);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          checkOutput("rsp_inst", 64'(i), 64'(r.inst));
          checkOutput("rsp_rdata", 64'(rsp_rdata[i]), 64'(r.rdata));
        end
      end
      prev_cs[i]   = cs[i];
      prev_sclk[i] = sclk[i];
      prev_mosi[i] = mosi[i];
    end
  end

  initial begin
    int waited;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 7'h00;
      req_wdata[i] = 32'h0;
      miso[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_req_ready", 64'(req_ready[i]), 64'd1);
      checkOutput("reset_rsp_valid", 64'(rsp_valid[i]), 64'd0);
      checkOutput("reset_rsp_rdata", 64'(rsp_rdata[i]), 64'd0);
      checkOutput("reset_cs", 64'(cs[i]), 64'd1);
      checkOutput("reset_sclk", 64'(sclk[i]), 64'd0);
      checkOutput("reset_mosi", 64'(mosi[i]), 64'd0);
    end

    $display("[TB] fast instance: CLK_DIV=1, GAP_CYCLES=0");
    applyStimulus(1, 1'b1, 7'h7F, 32'h0055AAFF, 32'h0, 40'hFF0055AAFF, 32'h0, 1'b0, waited);
    waitDone();
    applyStimulus(1, 1'b0, 7'h00, 32'h0, 32'hA5C30F81, 40'h0000000000, 32'hA5C30F81, 1'b0, waited);
    waitDone();
    applyStimulus(1, 1'b1, 7'h40, 32'h01020304, 32'h0, 40'hC001020304, 32'hA5C30F81, 1'b0, waited);
    waitDone();
`ifdef SPI_BUS_MASTER_TXN_CNT_EN
    checkOutput("txn_cnt_three", 64'(txn_cnt[1]), 64'd3);
    force dut1.txn_cnt = 16'hFFFF;
    @(negedge clk);
    release dut1.txn_cnt;
    applyStimulus(1, 1'b1, 7'h00, 32'h0, 32'h0, 40'h8000000000, 32'hA5C30F81, 1'b0, waited);
    waitDone();
    checkOutput("txn_cnt_wrap", 64'(txn_cnt[1]), 64'd0);
`endif

    $display("[TB] default instance: write then read");
    applyStimulus(0, 1'b1, 7'h15, 32'hDEADBEEF, 32'h0, 40'h95DEADBEEF, 32'h0, 1'b0, waited);
    waitDone();
    applyStimulus(0, 1'b0, 7'h03, 32'h0, 32'h12345678, 40'h0300000000, 32'h12345678, 1'b0, waited);
    waitDone();

    $display("[TB] req_valid held across two requests");
    applyStimulus(0, 1'b1, 7'h2A, 32'hCAFEF00D, 32'h0, 40'hAACAFEF00D, 32'h12345678, 1'b1, waited);
    applyStimulus(0, 1'b0, 7'h11, 32'h0, 32'h87654321, 40'h1100000000, 32'h87654321, 1'b0, waited);
    checks++;
    if (waited < 300) begin
      errors++;
      $display("[TB] FAIL held_off: second request accepted after %0d cycles, expected >= 300", waited);
    end
    waitDone();

    $display("[TB] asynchronous reset in byte 2");
    applyStimulus(0, 1'b0, 7'h05, 32'h0, 32'hFFFFFFFF, 40'h0500000000, 32'hFFFFFFFF, 1'b0, waited);
    repeat (200) @(negedge clk);
    abort[0] = 1'b1;
    void'(rsp_q.pop_back());
    rst[0] = 1'b1;
    #1;
    checkOutput("abort_cs", 64'(cs[0]), 64'd1);
    checkOutput("abort_sclk", 64'(sclk[0]), 64'd0);
    checkOutput("abort_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    applyStimulus(0, 1'b1, 7'h01, 32'h11223344, 32'h0, 40'h8111223344, 32'h0, 1'b0, waited);
    waitDone();
    applyStimulus(0, 1'b0, 7'h7E, 32'h0, 32'h0BADF00D, 40'h7E00000000, 32'h0BADF00D, 1'b0, waited);
    waitDone();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
